// File: rtl/bitaddr_ram_pkg.sv
// bitaddr_ram_pkg: shared FSM states and bit-area constants for bitaddr_ram
package bitaddr_ram_pkg;
  typedef enum logic [1:0] {IDLE, PTR, RMW, RESP} state_t;
  localparam logic [7:0] BIT_BASE_DEF = 8'h20;
  localparam int BIT_BYTES = 16;
endpackage

// File: rtl/bitaddr_ram_ram_sp.sv
// ram_sp: single-port synchronous RAM, DEPTH x 8, registered read (read-first)
module ram_sp #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/bitaddr_ram.sv
// bitaddr_ram: byte/bit-addressable data RAM with register banks and indirect access
module bitaddr_ram
  import bitaddr_ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int BANKS = 4,
  parameter logic [7:0] BIT_BASE = BIT_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rw,
  input  logic       bb,
  input  logic       ind,
  input  logic [1:0] bank_sel,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       bin,
  output logic       ready,
  output logic [7:0] dout,
  output logic       bout,
  output logic       rvalid,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [7:0] rdata, wdata, din_q, dout_q, byte_a, ri_a;
  logic [AW-1:0] raddr, addr_q;
  logic [2:0] bit_q;
  logic [1:0] bank;
  logic we, acc, bad, rw_q, bb_q, bin_q, bout_q, err_q, err_nx;
  assign acc = state == IDLE && !cs_n;
  assign bank = 2'(32'(bank_sel) % BANKS);
  assign byte_a = bb ? addr : BIT_BASE + {4'b0, addr[6:3]};
  assign ri_a = {3'b0, bank, 2'b0, addr[0]};
  assign bad = bb ? !ind && 32'(addr) >= DEPTH : 32'(addr) >= BIT_BYTES * 8;
  always_comb begin
    state_nx = state;
    err_nx = err_q;
    raddr = AW'(bb && ind ? ri_a : byte_a);
    we = 1'b0;
    wdata = din;
    case (state)
      IDLE: if (!cs_n) begin
        err_nx = bad;
        state_nx = bad ? RESP : bb && ind ? PTR : !bb && !rw ? RMW : rw ? RESP : IDLE;
        we = !bad && bb && !ind && !rw;
      end
      PTR: begin
        raddr = AW'(rdata);
        err_nx = 32'(rdata) >= DEPTH;
        we = !err_nx && !rw_q;
        wdata = din_q;
        state_nx = err_nx || rw_q ? RESP : IDLE;
      end
      RMW: begin
        raddr = addr_q;
        we = 1'b1;
        wdata = rdata;
        wdata[bit_q] = bin_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  ram_sp #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we && rst_n),
    .addr(raddr),
    .wdata(wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
      dout_q <= '0;
      bout_q <= 1'b0;
      rw_q <= 1'b0;
      bb_q <= 1'b0;
      bit_q <= '0;
      bin_q <= 1'b0;
      din_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (acc) begin
        rw_q <= rw;
        bb_q <= bb;
        bit_q <= addr[2:0];
        bin_q <= bin;
        din_q <= din;
        addr_q <= AW'(byte_a);
      end
      if (rvalid) begin
        dout_q <= rdata;
        if (!bb_q) bout_q <= rdata[bit_q];
      end
    end
  end
  assign ready = state == IDLE;
  assign rvalid = state == RESP && !err_q;
  assign err = state == RESP && err_q;
  assign dout = rvalid ? rdata : dout_q;
  assign bout = rvalid && !bb_q ? rdata[bit_q] : bout_q;
endmodule

// File: tb/tb_bitaddr_ram.sv
// tb_bitaddr_ram: randomized and directed checks of bitaddr_ram against a behavioural model
module tb_bitaddr_ram;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] cs_n = 2'b11;
  logic rw = 1'b0, bb = 1'b1, ind = 1'b0, bin = 1'b0;
  logic [1:0] bank_sel = '0;
  logic [7:0] addr = '0, din = '0;
  logic [1:0] rdy, rv, er, bo;
  logic [7:0] dq [2];
  logic [7:0] mem [2][256];
  logic [7:0] last [2];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  bitaddr_ram #(.DEPTH(256)) u0 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[0]), .rw(rw), .bb(bb), .ind(ind),
    .bank_sel(bank_sel), .addr(addr), .din(din), .bin(bin), .ready(rdy[0]),
    .dout(dq[0]), .bout(bo[0]), .rvalid(rv[0]), .err(er[0])
  );
  bitaddr_ram #(.DEPTH(128)) u1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[1]), .rw(rw), .bb(bb), .ind(ind),
    .bank_sel(bank_sel), .addr(addr), .din(din), .bin(bin), .ready(rdy[1]),
    .dout(dq[1]), .bout(bo[1]), .rvalid(rv[1]), .err(er[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s u%0d ready/rvalid/err", tag, k), {rdy[k], rv[k], er[k]}, 3'b100);
      check($sformatf("%s u%0d dout/bout", tag, k), {dq[k], bo[k]}, 9'h0);
    end
  endtask
  task automatic op(input int k, input bit r, input bit b, input bit i, input logic [1:0] bk,
                    input logic [7:0] a, input logic [7:0] d, input bit bi);
    int dep, l, rv_at, err_at, tgt;
    logic [7:0] ed;
    bit eb, chkb;
    dep = k ? 128 : 256;
    rv_at = 0; err_at = 0; chkb = 0; ed = '0; eb = 0;
    if (b) begin
      tgt = i ? int'(mem[k][int'(bk) * 8 + int'(a[0])]) : int'(a);
      l = i ? 2 : 1;
      if (tgt >= dep) err_at = l;
      else if (r) begin
        rv_at = l;
        ed = mem[k][tgt];
      end else begin
        l = l - 1;
        mem[k][tgt] = d;
      end
    end else begin
      l = 1;
      tgt = 32 + int'(a[6:3]);
      if (a >= 8'h80) err_at = 1;
      else if (r) begin
        rv_at = 1;
        ed = mem[k][tgt];
        eb = ed[a[2:0]];
        chkb = 1;
      end else mem[k][tgt][a[2:0]] = bi;
    end
    for (int t = 0; t < 20 && !rdy[k]; t++) begin
      @(posedge clk);
      #1;
    end
    check($sformatf("u%0d ready before accept", k), rdy[k], 1'b1);
    rw = r; bb = b; ind = i; bank_sel = bk; addr = a; din = d; bin = bi;
    cs_n[k] = 1'b0;
    @(posedge clk);
    #1;
    cs_n[k] = 1'b1;
    for (int c = 1; c <= l + 1; c++) begin
      check($sformatf("u%0d a=%0h cyc%0d ready/rvalid/err", k, a, c), {rdy[k], rv[k], er[k]},
            {c > l, c == rv_at, c == err_at});
      if (c == rv_at) begin
        check($sformatf("u%0d a=%0h dout", k, a), dq[k], ed);
        last[k] = ed;
        if (chkb) check($sformatf("u%0d a=%0h bout", k, a), bo[k], eb);
      end else check($sformatf("u%0d a=%0h dout hold", k, a), dq[k], last[k]);
      if (c <= l) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  initial begin
    last[0] = '0;
    last[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < (k ? 128 : 256); a++) op(k, 0, 1, 0, 2'd0, 8'(a), 8'($urandom), 0);
    op(0, 0, 1, 0, 2'd0, 8'h07, 8'h55, 0);
    op(0, 1, 1, 0, 2'd0, 8'h07, 8'h00, 0);
    check("byte read 0x07", last[0], 8'h55);
    op(0, 0, 1, 0, 2'd0, 8'h20, 8'h87, 0);
    op(0, 0, 0, 0, 2'd0, 8'h02, 8'h00, 0);
    op(0, 1, 0, 0, 2'd0, 8'h02, 8'h00, 0);
    op(0, 1, 1, 0, 2'd0, 8'h20, 8'h00, 0);
    check("byte 0x20 after bit clear", last[0], 8'h83);
    op(0, 0, 1, 0, 2'd2, 8'h11, 8'h30, 0);
    op(0, 0, 1, 0, 2'd2, 8'h30, 8'hA5, 0);
    op(0, 1, 1, 1, 2'd2, 8'h01, 8'h00, 0);
    check("indirect read via R1", last[0], 8'hA5);
    op(1, 0, 1, 0, 2'd0, 8'h20, 8'h3C, 0);
    op(1, 1, 1, 0, 2'd0, 8'h90, 8'h00, 0);
    op(1, 0, 0, 0, 2'd0, 8'h80, 8'h00, 1);
    op(1, 1, 1, 0, 2'd0, 8'h20, 8'h00, 0);
    check("byte 0x20 after rejected bit write", last[1], 8'h3C);
    op(0, 0, 1, 0, 2'd0, 8'h20, 8'h00, 0);
    op(0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    rw = 1'b0; bb = 1'b0; ind = 1'b0; addr = 8'h07; bin = 1'b1;
    cs_n[0] = 1'b0;
    @(posedge clk);
    #1;
    cs_n[0] = 1'b1;
    check("rmw ready low", rdy[0], 1'b0);
    rst_n = 1'b0;
    #1;
    last[0] = '0;
    last[1] = '0;
    check_idle("reset in rmw");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op(0, 1, 1, 0, 2'd0, 8'h20, 8'h00, 0);
    check("byte 0x20 after aborted rmw", last[0], 8'h00);
    for (int n = 0; n < 600; n++) begin
      int k;
      bit r, b, i;
      logic [7:0] a;
      k = n % 2;
      r = 1'($urandom);
      b = $urandom_range(0, 2) != 0;
      i = b && $urandom_range(0, 3) == 0;
      a = b ? 8'($urandom_range(0, k ? 8'h9F : 8'hFF)) : 8'($urandom_range(0, 8'h8F));
      op(k, r, b, i, 2'($urandom), a, 8'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bitaddr_ram.md
BITADDR_RAM -- requirements
Module: bitaddr_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data RAM bytes (power of two, 128..256).
REQ-002 SHALL have parameter BANKS, default 4, meaning register banks of 8 bytes each, starting at byte 0x00.
REQ-003 SHALL have parameter BIT_BASE, default 8'h20, meaning the first byte of the 16-byte bit-addressable area.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port cs_n, input, 1 bit: request strobe, active-low; the request is accepted when cs_n=0 and ready=1 at a rising edge.
REQ-007 SHALL have port rw, input, 1 bit: 1=read, 0=write.
REQ-008 SHALL have port bb, input, 1 bit: 1=byte access, 0=bit access.
REQ-009 SHALL have port ind, input, 1 bit: 1=indirect byte access through R0/R1 (addr[0] selects Ri); ignored when bb=0.
REQ-010 SHALL have port bank_sel, input, 2 bits: active register bank, sampled at accept.
REQ-011 SHALL have port addr, input, 8 bits: byte address (bb=1) or bit address 0x00-0x7F (bb=0).
REQ-012 SHALL have port din, input, 8 bits: byte write data.
REQ-013 SHALL have port bin, input, 1 bit: bit write data.
REQ-014 SHALL have port ready, output, 1 bit: block can accept a request this cycle.
REQ-015 SHALL have port dout, output, 8 bits: byte read data.
REQ-016 SHALL have port bout, output, 1 bit: bit read data.
REQ-017 SHALL have port rvalid, output, 1 bit: one-cycle pulse marking dout/bout valid.
REQ-018 SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected access.

Function
REQ-019 SHALL map bit address b to byte BIT_BASE+b[6:3], bit b[2:0].
REQ-020 SHALL map indirect Ri to byte bank_sel*8 + addr[0].
REQ-021 SHALL use FSM states IDLE, PTR, RMW, RESP; ready=1 only in IDLE.
REQ-022 SHALL complete a direct byte write at the accept edge, staying in IDLE (zero wait).
REQ-023 SHALL respond to a direct byte read via RESP, with rvalid=1 and dout valid in the cycle after accept (latency 1).
REQ-024 SHALL respond to a bit read with latency 1, bout = selected bit, dout = whole containing byte.
REQ-025 SHALL perform a bit write as read-modify-write: accept -> RMW (byte read), next edge writes the byte with only the target bit replaced; ready=0 for exactly 1 cycle.
REQ-026 SHALL fetch the pointer in PTR for an indirect access, adding exactly 1 cycle to the latency of REQ-022/REQ-023.
REQ-027 SHALL pulse err in the cycle after accept, with no write and no rvalid, when the byte address or pointer is >= DEPTH or the bit address is >= 0x80.
REQ-028 SHALL ignore cs_n while ready=0; the requester holds the request until accepted.
REQ-029 SHALL return data written at edge N to a read accepted at edge N+1 (no stale data).
REQ-030 SHALL hold dout/bout until the next rvalid.

Reset
REQ-031 SHALL force state IDLE, ready=1, dout=0, bout=0, rvalid=0, err=0 when rst_n=0.
REQ-032 SHALL leave RAM contents undefined after reset (not cleared).
REQ-033 SHALL abort the write on reset during RMW or PTR, leaving the target byte unchanged.

Structure
REQ-034 SHALL define the state enum, the default BIT_BASE and the bit-area size (16) in package bitaddr_ram_pkg.
REQ-035 SHALL instantiate one sub-module, ram_sp: a single-port synchronous RAM, DEPTH x 8, with 1-cycle read.

Verification
REQ-036 SHALL verify: byte write 0x55 to 0x07, bank 0, then read 0x07 -> rvalid next cycle, dout=0x55.
REQ-037 SHALL verify: write 0x87 to 0x20, bit write bin=0 to bit 0x02, then bit read 0x02 -> bout=0, byte 0x20 = 0x83, ready low 1 cycle during RMW.
REQ-038 SHALL verify: bank_sel=2, R1 (0x11) = 0x30, 0x30 = 0xA5, indirect read addr[0]=1 -> dout=0xA5 two cycles after accept.
REQ-039 SHALL verify: DEPTH=128, read 0x90 -> err pulse, no rvalid; bit write at bit address 0x80 -> err, RAM unchanged.
REQ-040 SHALL verify: rst_n low during RMW of bit 0x07 on byte 0x20=0x00 -> after reset ready=1, outputs 0, byte 0x20 still 0x00.
